// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the VGA overlay blocks.
//   - Video geometry and colour depth constants.
//   - color_t: one 12-bit {R,G,B} pixel (4 bits per channel).
//   - clamp_step(): moves a coordinate by a signed delta and clamps the
//     result into [lo, hi]. The arithmetic is done two bits wider than the
//     coordinate so that neither a step below zero nor a step past the top
//     of the coordinate range can wrap around.
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int VIDEO_WIDTH    = 640;
    localparam int VIDEO_HEIGHT   = 480;
    localparam int BITS_PER_COLOR = 12;

    // Working width of clamp_step(); any coordinate up to 16 bits fits.
    localparam int CLAMP_W = 16;

    typedef logic [BITS_PER_COLOR-1:0] color_t;

    function automatic logic [CLAMP_W-1:0] clamp_step(
        input logic        [CLAMP_W-1:0] pos,
        input logic signed [CLAMP_W:0]   delta,
        input logic        [CLAMP_W-1:0] lo,
        input logic        [CLAMP_W-1:0] hi
    );
        logic signed [CLAMP_W+1:0] sum;
        sum = $signed({2'b00, pos}) + $signed({delta[CLAMP_W], delta});
        if (sum < $signed({2'b00, lo})) begin
            clamp_step = lo;
        end else if (sum > $signed({2'b00, hi})) begin
            clamp_step = hi;
        end else begin
            clamp_step = sum[CLAMP_W-1:0];
        end
    endfunction

endpackage

// File: rtl/vga_box_hit.sv
// ---------------------------------------------------------------------------
// vga_box_hit
//   Purely combinational test of whether pixel (x, y) lies inside a square
//   box of edge BOX_SIZE whose top-left corner is (pos_x, pos_y).
//   The box covers pos_x <= x < pos_x+BOX_SIZE (same for y).
//
// Ports
//   x, y          in   COORD_W  current pixel coordinate
//   pos_x, pos_y  in   COORD_W  top-left corner of the box
//   in_box        out  1        pixel is inside the box
// ---------------------------------------------------------------------------
module vga_box_hit
    import vga_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int BOX_SIZE = 35
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    output logic               in_box
);

    // One extra bit so pos+BOX_SIZE cannot overflow near the top of range.
    logic [COORD_W:0] x_ext;
    logic [COORD_W:0] y_ext;
    logic [COORD_W:0] x_lo;
    logic [COORD_W:0] y_lo;
    logic [COORD_W:0] x_hi;
    logic [COORD_W:0] y_hi;

    assign x_ext = {1'b0, x};
    assign y_ext = {1'b0, y};
    assign x_lo  = {1'b0, pos_x};
    assign y_lo  = {1'b0, pos_y};
    assign x_hi  = x_lo + (COORD_W+1)'(BOX_SIZE);
    assign y_hi  = y_lo + (COORD_W+1)'(BOX_SIZE);

    assign in_box = (x_ext >= x_lo) && (x_ext < x_hi) &&
                    (y_ext >= y_lo) && (y_ext < y_hi);

endmodule

// File: rtl/vga_box_overlay.sv
// ---------------------------------------------------------------------------
// vga_box_overlay
//   Overlays NUM_BOXES movable square boxes on the background pixel stream
//   coming from the VGA timing generator / palette.
//   - One box at a time is selected; the select button's rising edge steps
//     the selection round-robin.
//   - Direction buttons move the selected box by STEP pixels once every
//     MOVE_DIV frames, clamped so the box always stays inside the map.
//   - Boxes are composited with fixed priority (lowest index on top).
//
//   Pixel stream: there is no handshake. A new (x, y, bg_color, active)
//   sample is accepted on every clk edge and its result appears on
//   color_out/hit exactly one clk later; active acts as the only
//   qualifier (blanking forces black and no hit).
//
// Ports
//   clk        in   1        system clock
//   reset      in   1        synchronous, active-low reset
//   frame_end  in   1        end-of-frame level from the timing generator
//   active     in   1        visible-pixel qualifier
//   x, y       in   COORD_W  current pixel coordinate
//   bg_color   in   12       background colour for (x, y)
//   btn_up/btn_down/btn_left/btn_right  in 1  direction buttons (level)
//   btn_sel    in   1        select button (level)
//   color_out  out  12       registered composited colour {R,G,B}
//   hit        out  1        registered: pixel inside at least one box
//   sel_idx    out  SEL_W    index of the selected box
//
//   INIT_POS packs {y, x} per box, box i at slice i; BOX_COLORS packs one
//   12-bit colour per box, box i at slice i. The defaults are written for
//   the default NUM_BOXES/COORD_W and must be overridden with them.
// ---------------------------------------------------------------------------
module vga_box_overlay
    import vga_pkg::*;
#(
    parameter int NUM_BOXES = 4,
    parameter int COORD_W   = 10,
    parameter int BOX_SIZE  = 35,
    parameter int STEP      = 1,
    parameter int MOVE_DIV  = 1,
    parameter int MAP_XMIN  = 50,
    parameter int MAP_XMAX  = 480,
    parameter int MAP_YMIN  = 50,
    parameter int MAP_YMAX  = 480,
    parameter logic [NUM_BOXES*2*COORD_W-1:0] INIT_POS = {
        10'd300, 10'd300,   // box 3 {y, x}
        10'd110, 10'd110,   // box 2
        10'd100, 10'd300,   // box 1
        10'd100, 10'd100    // box 0
    },
    parameter logic [NUM_BOXES*BITS_PER_COLOR-1:0] BOX_COLORS = {
        12'h888, 12'h800, 12'h080, 12'h008
    },
    localparam int SEL_W = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_end,
    input  logic                      active,
    input  logic [COORD_W-1:0]        x,
    input  logic [COORD_W-1:0]        y,
    input  logic [BITS_PER_COLOR-1:0] bg_color,
    input  logic                      btn_up,
    input  logic                      btn_down,
    input  logic                      btn_left,
    input  logic                      btn_right,
    input  logic                      btn_sel,
    output logic [BITS_PER_COLOR-1:0] color_out,
    output logic                      hit,
    output logic [SEL_W-1:0]          sel_idx
);

    // Highest legal top-left corner so the whole box stays inside the map.
    localparam int X_HI = MAP_XMAX - BOX_SIZE;
    localparam int Y_HI = MAP_YMAX - BOX_SIZE;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [COORD_W-1:0] pos_x [NUM_BOXES];
    logic [COORD_W-1:0] pos_y [NUM_BOXES];
    logic               fe_prev;
    logic               sel_prev;
    logic [7:0]         div_cnt;

    // -----------------------------------------------------------------------
    // Event detection
    // -----------------------------------------------------------------------
    logic frame_ev;
    logic div_wrap;
    logic move_ev;
    logic sel_ev;

    // frame_end can stay high for several clocks; only its rising edge
    // counts, so a long pulse still yields one frame event.
    assign frame_ev = frame_end & ~fe_prev;
    assign sel_ev   = btn_sel & ~sel_prev;
    assign div_wrap = (div_cnt == 8'(MOVE_DIV - 1));
    assign move_ev  = frame_ev & div_wrap;

    // -----------------------------------------------------------------------
    // Next position of the selected box
    // -----------------------------------------------------------------------
    logic signed [CLAMP_W:0] dx;
    logic signed [CLAMP_W:0] dy;
    logic [COORD_W-1:0]      cur_x;
    logic [COORD_W-1:0]      cur_y;
    logic [COORD_W-1:0]      nx;
    logic [COORD_W-1:0]      ny;

    // Opposite buttons cancel on their axis; each axis is independent.
    always_comb begin
        dx = '0;
        dy = '0;
        if (btn_right && !btn_left) begin
            dx = $signed((CLAMP_W+1)'(STEP));
        end else if (btn_left && !btn_right) begin
            dx = -$signed((CLAMP_W+1)'(STEP));
        end
        if (btn_down && !btn_up) begin
            dy = $signed((CLAMP_W+1)'(STEP));
        end else if (btn_up && !btn_down) begin
            dy = -$signed((CLAMP_W+1)'(STEP));
        end
    end

    assign cur_x = pos_x[sel_idx];
    assign cur_y = pos_y[sel_idx];

    // The clamp also runs with a zero delta, which is what pulls an
    // out-of-range initial position back inside on the first move event.
    assign nx = COORD_W'(clamp_step(CLAMP_W'(cur_x), dx,
                                    CLAMP_W'(MAP_XMIN), CLAMP_W'(X_HI)));
    assign ny = COORD_W'(clamp_step(CLAMP_W'(cur_y), dy,
                                    CLAMP_W'(MAP_YMIN), CLAMP_W'(Y_HI)));

    // -----------------------------------------------------------------------
    // Selection
    // -----------------------------------------------------------------------
    logic [SEL_W-1:0] sel_next;

    always_comb begin
        sel_next = '0;
        if (sel_idx != SEL_W'(NUM_BOXES - 1)) begin
            sel_next = sel_idx + SEL_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Hit test and priority compositing
    // -----------------------------------------------------------------------
    logic [NUM_BOXES-1:0] in_box;
    color_t               win_color;
    logic                 any_hit;
    color_t               pix_color;
    logic                 pix_hit;

    for (genvar g = 0; g < NUM_BOXES; g++) begin : g_box
        vga_box_hit #(
            .COORD_W  (COORD_W),
            .BOX_SIZE (BOX_SIZE)
        ) u_hit (
            .x      (x),
            .y      (y),
            .pos_x  (pos_x[g]),
            .pos_y  (pos_y[g]),
            .in_box (in_box[g])
        );
    end

    // Walk from the highest index down so the lowest hit index is written
    // last and therefore wins.
    always_comb begin
        win_color = '0;
        any_hit   = 1'b0;
        for (int i = NUM_BOXES - 1; i >= 0; i--) begin
            if (in_box[i]) begin
                any_hit   = 1'b1;
                win_color = BOX_COLORS[i*BITS_PER_COLOR +: BITS_PER_COLOR];
            end
        end
    end

    always_comb begin
        pix_color = '0;
        pix_hit   = 1'b0;
        if (active) begin
            pix_hit   = any_hit;
            pix_color = any_hit ? win_color : bg_color;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BOXES; i++) begin
                pos_x[i] <= INIT_POS[i*2*COORD_W +: COORD_W];
                pos_y[i] <= INIT_POS[i*2*COORD_W + COORD_W +: COORD_W];
            end
            sel_idx   <= '0;
            div_cnt   <= '0;
            fe_prev   <= 1'b0;
            sel_prev  <= 1'b0;
            color_out <= '0;
            hit       <= 1'b0;
        end else begin
            fe_prev  <= frame_end;
            sel_prev <= btn_sel;

            if (frame_ev) begin
                div_cnt <= div_wrap ? 8'd0 : div_cnt + 8'd1;
            end

            // Uses the current sel_idx, so a select edge in the same cycle
            // only affects later moves.
            if (move_ev) begin
                pos_x[sel_idx] <= nx;
                pos_y[sel_idx] <= ny;
            end

            if (sel_ev) begin
                sel_idx <= sel_next;
            end

            color_out <= pix_color;
            hit       <= pix_hit;
        end
    end

endmodule
